mem_arbiter: RTL and testbench

- Shares the single RAM port between instruction fetch (icache/IF) and data access (dcache/MEM).
- Sequences one RAM transaction at a time and returns registered one-cycle ihit/dhit pulses; these pulses feed the hazard unit's stall/enable logic.
- Data has priority over instruction fetch. A streak limit prevents fetch starvation.
- A watchdog flags a RAM port that never completes.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every signal that crosses the memory arbiter boundary: the fetch
// request (iREN/iaddr), the data request (dREN/dWEN/daddr/dstore), the single
// RAM port (ramREN/ramWEN/ramaddr/ramstore with ram_ready/ram_load) and the
// completion side (ihit/dhit/iload/dload/err).
//   slave  : the arbiter's view (requests and RAM response in, strobes out)
//   master : the environment's view (caches plus RAM model drive, observe)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
);
   // instruction fetch side
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   // data access side
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   // RAM port
   logic              ram_ready;
   logic [WORD_W-1:0] ram_load;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   // completion
   logic              ihit;
   logic              dhit;
   logic [WORD_W-1:0] iload;
   logic [WORD_W-1:0] dload;
   logic              err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
      output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
      input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one RAM port between instruction fetch and data access. One RAM
// transaction is in flight at a time; completion is reported with registered
// one-cycle ihit/dhit pulses. Data wins arbitration, but after MAX_DSTREAK
// consecutive data grants taken while a fetch waits, the fetch is granted.
// A watchdog aborts an access that stays incomplete for TIMEOUT cycles and
// raises a sticky err flag.
// Ports:
//   CLK  : clock, all state updates on the rising edge
//   RST  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave (requests, RAM port, hits, load data, err)
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int WORD_W      = 32,
   parameter int MAX_DSTREAK = 4,   // 1..15
   parameter int TIMEOUT     = 15   // 1..255
) (
   input  logic         CLK,
   input  logic         RST,
   mem_arbiter_if.slave bus
);

   localparam logic [3:0] MAX_STREAK_C = 4'(MAX_DSTREAK);
   localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DACC  = 3'd1,
      S_IACC  = 3'd2,
      S_IDONE = 3'd3,
      S_DDONE = 3'd4
   } state_t;

   state_t            state_q;
   logic [3:0]        streak_q;
   logic [7:0]        wdog_q;
   logic              ihit_q;
   logic              dhit_q;
   logic              err_q;
   logic [WORD_W-1:0] iload_q;
   logic [WORD_W-1:0] dload_q;

   logic              dreq_s;
   logic              grant_d_s;
   logic              wdog_expire_s;
   logic [7:0]        wdog_d;
   logic [3:0]        streak_up_d;

   // Arbitration terms and the counter candidates used by the FSM.
   assign dreq_s        = bus.dREN | bus.dWEN;
   // Data wins unless a fetch is waiting and the data streak is used up.
   assign grant_d_s     = dreq_s & (~bus.iREN | (streak_q < MAX_STREAK_C));
   assign wdog_d        = wdog_q + 8'd1;
   assign wdog_expire_s = (wdog_d == TIMEOUT_C);
   assign streak_up_d   = (streak_q < MAX_STREAK_C) ? (streak_q + 4'd1) : MAX_STREAK_C;

   // Main FSM: state, streak, watchdog, hit pulses, load capture and err.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         streak_q <= 4'd0;
         wdog_q   <= 8'd0;
         ihit_q   <= 1'b0;
         dhit_q   <= 1'b0;
         err_q    <= 1'b0;
         iload_q  <= {WORD_W{1'b0}};
         dload_q  <= {WORD_W{1'b0}};
      end else begin
         ihit_q <= 1'b0;
         dhit_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               wdog_q <= 8'd0;
               if (grant_d_s) begin
                  state_q <= S_DACC;
                  // Only data grants taken over a waiting fetch extend the streak.
                  streak_q <= bus.iREN ? streak_up_d : 4'd0;
               end else if (bus.iREN) begin
                  state_q  <= S_IACC;
                  streak_q <= 4'd0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_DACC: begin
               if (bus.ram_ready) begin
                  // Writes leave dload untouched.
                  if (bus.dREN && !bus.dWEN) begin
                     dload_q <= bus.ram_load;
                  end else begin
                     dload_q <= dload_q;
                  end
                  dhit_q  <= 1'b1;
                  wdog_q  <= 8'd0;
                  state_q <= S_DDONE;
               end else if (wdog_expire_s) begin
                  err_q   <= 1'b1;
                  wdog_q  <= 8'd0;
                  state_q <= S_IDLE;
               end else begin
                  wdog_q <= wdog_d;
               end
            end
            S_IACC: begin
               if (bus.ram_ready) begin
                  iload_q <= bus.ram_load;
                  ihit_q  <= 1'b1;
                  wdog_q  <= 8'd0;
                  state_q <= S_IDONE;
               end else if (wdog_expire_s) begin
                  err_q   <= 1'b1;
                  wdog_q  <= 8'd0;
                  state_q <= S_IDLE;
               end else begin
                  wdog_q <= wdog_d;
               end
            end
            // DONE states exist only to present the hit pulse; no grant
            // is made out of them, requests are sampled again in IDLE.
            S_IDONE: begin
               state_q <= S_IDLE;
            end
            S_DDONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               wdog_q  <= 8'd0;
            end
         endcase
      end
   end

   // RAM strobes follow the current state and live request inputs; they are
   // forced low while RST is sampled so an aborted access drops at once.
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = {ADDR_W{1'b0}};
      bus.ramstore = {WORD_W{1'b0}};
      if (RST) begin
         bus.ramREN = 1'b0;
      end else begin
         case (state_q)
            S_DACC: begin
               bus.ramaddr  = bus.daddr;
               bus.ramWEN   = bus.dWEN;
               bus.ramREN   = bus.dREN & ~bus.dWEN;   // write wins
               bus.ramstore = bus.dstore;
            end
            S_IACC: begin
               bus.ramaddr = bus.iaddr;
               bus.ramREN  = 1'b1;
            end
            default: begin
               bus.ramREN = 1'b0;
            end
         endcase
      end
   end

   assign bus.ihit  = ihit_q;
   assign bus.dhit  = dhit_q;
   assign bus.iload = iload_q;
   assign bus.dload = dload_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam int MAXS = 4;
   localparam int TOUT = 15;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   logic [31:0] exp_iload;
   logic [31:0] exp_dload;

   mem_arbiter_if #(.ADDR_W(32), .WORD_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .WORD_W(32), .MAX_DSTREAK(MAXS), .TIMEOUT(TOUT)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.iREN = 1'b0; bus.iaddr = 32'h0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
      bus.ram_ready = 1'b0; bus.ram_load = 32'h0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b1; clear_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      exp_iload = 32'h0; exp_dload = 32'h0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1; rst = 1'b1; bus.iREN = 1'b1; bus.dREN = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== 34'h0) begin
         $display("FAIL reset_strobes: got %h expected 0", {bus.ramREN, bus.ramWEN, bus.ramaddr}); tests_failed++;
      end
      tests_run++;
      if ({bus.ihit, bus.dhit, bus.err} !== 3'b000) begin
         $display("FAIL reset_flags: got %b expected 000", {bus.ihit, bus.dhit, bus.err}); tests_failed++;
      end
      tests_run++;
      if ({bus.iload, bus.dload} !== 64'h0) begin
         $display("FAIL reset_loads: got %h expected 0", {bus.iload, bus.dload}); tests_failed++;
      end
      @(posedge clk); #1; rst = 1'b0; clear_inputs();
      exp_iload = 32'h0; exp_dload = 32'h0;
      @(negedge clk);
      tests_run++;
      if (bus.ramREN !== 1'b0) begin
         $display("FAIL reset_idle: ramREN got %b expected 0", bus.ramREN); tests_failed++;
      end
   endtask

   task automatic test_ifetch();
      @(posedge clk); #1;
      bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ram_ready = 1'b1; bus.ram_load = 32'h8C010004;
      @(negedge clk);
      tests_run++;
      if (bus.ramREN !== 1'b0) begin
         $display("FAIL ifetch_c1: ramREN got %b expected 0", bus.ramREN); tests_failed++;
      end
      @(posedge clk); #1; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b10, 32'h100}) begin
         $display("FAIL ifetch_c2: got %h expected %h", {bus.ramREN, bus.ramWEN, bus.ramaddr}, {2'b10, 32'h100}); tests_failed++;
      end
      @(posedge clk); #1; @(negedge clk);
      exp_iload = 32'h8C010004;
      tests_run++;
      if ({bus.ihit, bus.dhit, bus.iload} !== {2'b10, exp_iload}) begin
         $display("FAIL ifetch_c3: got %h expected %h", {bus.ihit, bus.dhit, bus.iload}, {2'b10, exp_iload}); tests_failed++;
      end
      @(posedge clk); #1; bus.iREN = 1'b0; bus.ram_ready = 1'b0; @(negedge clk);
      tests_run++;
      if (bus.ihit !== 1'b0) begin
         $display("FAIL ifetch_c4: ihit got %b expected 0", bus.ihit); tests_failed++;
      end
   endtask

   task automatic test_write_priority();
      @(posedge clk); #1;
      bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
      bus.iREN = 1'b1; bus.iaddr = 32'h104; bus.ram_ready = 1'b1; bus.ram_load = 32'h11112222;
      @(posedge clk); #1; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== {2'b01, 32'h200, 32'hDEADBEEF}) begin
         $display("FAIL wr_dacc: got %h expected %h", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore},
                  {2'b01, 32'h200, 32'hDEADBEEF}); tests_failed++;
      end
      @(posedge clk); #1; @(negedge clk);
      tests_run++;
      if ({bus.dhit, bus.ihit, bus.ramWEN} !== 3'b100) begin
         $display("FAIL wr_dhit: got %b expected 100", {bus.dhit, bus.ihit, bus.ramWEN}); tests_failed++;
      end
      @(posedge clk); #1; bus.dWEN = 1'b0; @(negedge clk);
      tests_run++;
      if ({bus.dhit, bus.ramREN} !== 2'b00) begin
         $display("FAIL wr_idle: got %b expected 00", {bus.dhit, bus.ramREN}); tests_failed++;
      end
      @(posedge clk); #1; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b10, 32'h104}) begin
         $display("FAIL wr_iacc: got %h expected %h", {bus.ramREN, bus.ramWEN, bus.ramaddr}, {2'b10, 32'h104}); tests_failed++;
      end
      @(posedge clk); #1; @(negedge clk);
      exp_iload = 32'h11112222;
      tests_run++;
      if ({bus.ihit, bus.iload, bus.dload} !== {1'b1, exp_iload, exp_dload}) begin
         $display("FAIL wr_ihit: got %h expected %h", {bus.ihit, bus.iload, bus.dload}, {1'b1, exp_iload, exp_dload}); tests_failed++;
      end
      @(posedge clk); #1; bus.iREN = 1'b0; bus.ram_ready = 1'b0;
   endtask

   task automatic test_streak();
      bit exp_d [10];
      int s = 0;
      int n = 0;
      int cyc = 0;
      bit prev_strobe = 1'b0;
      bit got_d;
      for (int g = 0; g < 10; g++) begin
         if (s < MAXS) begin exp_d[g] = 1'b1; s++; end
         else begin exp_d[g] = 1'b0; s = 0; end
      end
      do_reset();
      @(posedge clk); #1;
      bus.iREN = 1'b1; bus.iaddr = 32'h400; bus.dREN = 1'b1; bus.daddr = 32'h500;
      bus.ram_ready = 1'b1; bus.ram_load = 32'h5A5A0000;
      while (n < 10 && cyc < 200) begin
         @(negedge clk);
         if (bus.ramREN && !prev_strobe) begin
            got_d = (bus.ramaddr == 32'h500);
            tests_run++;
            if (got_d !== exp_d[n]) begin
               $display("FAIL streak_grant%0d: got D=%b expected D=%b", n, got_d, exp_d[n]); tests_failed++;
            end
            n++;
         end
         prev_strobe = bus.ramREN;
         @(posedge clk); #1;
         cyc++;
      end
      tests_run++;
      if (n != 10) begin
         $display("FAIL streak_timeout: got %0d grants expected 10", n); tests_failed++;
      end
      bus.iREN = 1'b0; bus.dREN = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      exp_iload = 32'h5A5A0000; exp_dload = 32'h5A5A0000;
   endtask

   task automatic test_timeout();
      int acc_cnt = 0;
      bit saw_ihit = 1'b0;
      @(posedge clk); #1;
      bus.iREN = 1'b1; bus.iaddr = 32'h600; bus.ram_ready = 1'b0; bus.ram_load = 32'hBAD0BAD0;
      @(negedge clk);
      for (int c = 2; c <= 16; c++) begin
         @(posedge clk); #1; @(negedge clk);
         if (bus.ramREN === 1'b1 && bus.ramaddr === 32'h600) acc_cnt++;
         if (bus.ihit !== 1'b0) saw_ihit = 1'b1;
      end
      tests_run++;
      if (bus.err !== 1'b0) begin
         $display("FAIL to_early_err: got %b expected 0", bus.err); tests_failed++;
      end
      @(posedge clk); #1; bus.iREN = 1'b0; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.err, saw_ihit} !== 3'b010) begin
         $display("FAIL to_abort: ramREN,err,ihit got %b expected 010", {bus.ramREN, bus.err, saw_ihit}); tests_failed++;
      end
      tests_run++;
      if (acc_cnt != TOUT) begin
         $display("FAIL to_cycles: got %0d expected %0d", acc_cnt, TOUT); tests_failed++;
      end
      repeat (3) begin
         @(posedge clk); #1; @(negedge clk);
         if (bus.ihit !== 1'b0) saw_ihit = 1'b1;
      end
      tests_run++;
      if ({bus.err, saw_ihit, bus.iload} !== {2'b10, exp_iload}) begin
         $display("FAIL to_sticky: got %h expected %h", {bus.err, saw_ihit, bus.iload}, {2'b10, exp_iload}); tests_failed++;
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1; bus.dREN = 1'b1; bus.daddr = 32'h2F0; bus.ram_ready = 1'b0;
      @(posedge clk); #1; @(negedge clk);
      tests_run++;
      if (bus.ramREN !== 1'b1) begin
         $display("FAIL rstmid_dacc: ramREN got %b expected 1", bus.ramREN); tests_failed++;
      end
      @(posedge clk); #1; rst = 1'b1; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.ramaddr} !== 33'h0) begin
         $display("FAIL rstmid_drop: got %h expected 0", {bus.ramREN, bus.ramaddr}); tests_failed++;
      end
      @(posedge clk); #1; rst = 1'b0; bus.dREN = 1'b0; @(negedge clk);
      exp_iload = 32'h0; exp_dload = 32'h0;
      tests_run++;
      if ({bus.ramREN, bus.dhit, bus.err, bus.dload} !== {3'b000, exp_dload}) begin
         $display("FAIL rstmid_idle: got %h expected %h", {bus.ramREN, bus.dhit, bus.err, bus.dload}, {3'b000, exp_dload}); tests_failed++;
      end
      @(posedge clk); #1; bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ram_ready = 1'b1; bus.ram_load = 32'hCAFEF00D;
      @(posedge clk); #1; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h300}) begin
         $display("FAIL rstmid_read: got %h expected %h", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h300}); tests_failed++;
      end
      @(posedge clk); #1; @(negedge clk);
      exp_dload = 32'hCAFEF00D;
      tests_run++;
      if ({bus.dhit, bus.dload} !== {1'b1, exp_dload}) begin
         $display("FAIL rstmid_dhit: got %h expected %h", {bus.dhit, bus.dload}, {1'b1, exp_dload}); tests_failed++;
      end
      @(posedge clk); #1; bus.dREN = 1'b0; bus.ram_ready = 1'b0;
   endtask

   task automatic test_delayed_ready();
      @(posedge clk); #1; bus.dREN = 1'b1; bus.daddr = 32'h700; bus.ram_ready = 1'b0; bus.ram_load = 32'h12345678;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.dhit} !== 2'b10) begin
         $display("FAIL dly_wait: got %b expected 10", {bus.ramREN, bus.dhit}); tests_failed++;
      end
      @(posedge clk); #1; bus.ram_ready = 1'b1; @(negedge clk);
      tests_run++;
      if ({bus.ramREN, bus.dhit} !== 2'b10) begin
         $display("FAIL dly_ready: got %b expected 10", {bus.ramREN, bus.dhit}); tests_failed++;
      end
      @(posedge clk); #1; bus.ram_ready = 1'b0; @(negedge clk);
      exp_dload = 32'h12345678;
      tests_run++;
      if ({bus.dhit, bus.dload, bus.iload} !== {1'b1, exp_dload, exp_iload}) begin
         $display("FAIL dly_dhit: got %h expected %h", {bus.dhit, bus.dload, bus.iload}, {1'b1, exp_dload, exp_iload}); tests_failed++;
      end
      @(posedge clk); #1; bus.dREN = 1'b0; @(negedge clk);
      tests_run++;
      if (bus.dhit !== 1'b0) begin
         $display("FAIL dly_pulse: dhit got %b expected 0", bus.dhit); tests_failed++;
      end
   endtask

   // Transaction-level model: grants decided from the requests seen in the
   // last idle cycle, hits one cycle after ram_ready, one idle cycle after.
   task automatic test_random();
      bit ipend = 0, dpend = 0, dwr = 0;
      bit prev_i = 0, prev_d = 0, free_prev = 1;
      bit rdy;
      int active = 0, hit_due = 0, hit_last = 0, streak = 0, wait_rdy = 0;
      int iage = 0, dage = 0;
      bit starved = 0;
      logic [31:0] ia = 0, da = 0, ds = 0, ld;
      logic [65:0] exp_bus;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         if (hit_last == 1) ipend = 1'b0;
         else if (!ipend && $urandom_range(0, 2) == 0) begin ipend = 1'b1; ia = $urandom; end
         if (hit_last == 2) dpend = 1'b0;
         else if (!dpend && $urandom_range(0, 2) == 0) begin
            dpend = 1'b1; dwr = 1'($urandom_range(0, 1)); da = $urandom; ds = $urandom;
         end
         rdy = (wait_rdy >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
         wait_rdy = rdy ? 0 : wait_rdy + 1;
         ld = $urandom;
         bus.iREN = ipend; bus.iaddr = ia;
         bus.dREN = dpend & ~dwr; bus.dWEN = dpend & dwr; bus.daddr = da; bus.dstore = ds;
         bus.ram_ready = rdy; bus.ram_load = ld;
         @(negedge clk);
         if (free_prev && (prev_i || prev_d)) begin
            if (prev_d && (!prev_i || streak < MAXS)) begin
               active = 2; streak = prev_i ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            end else begin
               active = 1; streak = 0;
            end
         end
         if (active == 1) exp_bus = {2'b10, ia, 32'h0};
         else if (active == 2) exp_bus = {~dwr, dwr, da, ds};
         else exp_bus = 66'h0;
         tests_run++;
         if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== exp_bus) begin
            $display("FAIL rnd_bus@%0d: got %h expected %h", cyc,
                     {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}, exp_bus); tests_failed++;
         end
         tests_run++;
         if ({bus.ihit, bus.dhit} !== {hit_due == 1, hit_due == 2}) begin
            $display("FAIL rnd_hit@%0d: got %b expected %b", cyc, {bus.ihit, bus.dhit},
                     {hit_due == 1, hit_due == 2}); tests_failed++;
         end
         tests_run++;
         if ({bus.iload, bus.dload} !== {exp_iload, exp_dload}) begin
            $display("FAIL rnd_load@%0d: got %h expected %h", cyc, {bus.iload, bus.dload},
                     {exp_iload, exp_dload}); tests_failed++;
         end
         free_prev = (active == 0 && hit_due == 0);
         hit_last = hit_due;
         hit_due = 0;
         if (active != 0 && rdy) begin
            hit_due = active;
            if (active == 1) exp_iload = ld;
            else if (!dwr) exp_dload = ld;
            active = 0;
         end
         prev_i = ipend; prev_d = dpend;
         iage = ipend ? iage + 1 : 0;
         dage = dpend ? dage + 1 : 0;
         if (iage > 100 || dage > 100) starved = 1'b1;
      end
      tests_run++;
      if ({starved, bus.err} !== 2'b00) begin
         $display("FAIL rnd_starve_err: got %b expected 00", {starved, bus.err}); tests_failed++;
      end
      @(posedge clk); #1; clear_inputs();
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      exp_iload = 32'h0;
      exp_dload = 32'h0;
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_ifetch();
      test_write_priority();
      test_streak();
      test_timeout();
      test_reset_mid();
      test_delayed_ready();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench time limit expired");
   end
endmodule
